banked_bram_arbiter: RTL and testbench
======================================

BANKED_BRAM_ARBITER -- requirements
Module: banked_bram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: word width of every port and bank; multiple of 8.
REQ-002 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: byte-strobe width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: word address width of the whole memory.
REQ-004 SHALL have parameter NUM_PORTS, default 2: number of request ports, 1..8.
REQ-005 SHALL have parameter BANKS, default 4: bank count, a power of 2, at most 2**ADDR_WIDTH.
REQ-006 SHALL have port clk, input, 1: the only clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port req_valid, input, NUM_PORTS: per-port access request.
REQ-009 SHALL have port req_ready, output, NUM_PORTS: per-port grant. An access is accepted when req_valid and req_ready are both high.
REQ-010 SHALL have port req_wren, input, NUM_PORTS: 1 = write, 0 = read.
REQ-011 SHALL have port req_wrstrb, input, NUM_PORTS*STRB_WIDTH: per-port byte enables.
REQ-012 SHALL have port req_addr, input, NUM_PORTS*ADDR_WIDTH: per-port word address.
REQ-013 SHALL have port req_din, input, NUM_PORTS*DATA_WIDTH: per-port write data.
REQ-014 SHALL have port rsp_valid, output, NUM_PORTS: per-port read-data strobe, one cycle wide.
REQ-015 SHALL have port rsp_dout, output, NUM_PORTS*DATA_WIDTH: per-port read data, valid when rsp_valid is high.

Function
REQ-016 SHALL select the bank from addr[log2(BANKS)-1:0] (low-order interleave); the in-bank row is the remaining upper bits.
REQ-017 SHALL grant each bank to at most one port per cycle; ports addressing different banks SHALL all be granted in the same cycle.
REQ-018 SHALL compute req_ready combinationally from the current cycle's req_valid/req_addr; no request-to-grant register.
REQ-019 SHALL arbitrate each bank round-robin:
  - per-bank pointer, reset 0;
  - highest priority is the pointer's port, then ascending port index modulo NUM_PORTS;
  - after any grant, pointer = granted index + 1 modulo NUM_PORTS;
  - no grant leaves the pointer unchanged.
REQ-020 SHALL keep a losing port's req_ready low; that port holds its request; no request is dropped.
REQ-021 SHALL write only the bytes whose req_wrstrb bit is 1. A write with an all-zero strobe is accepted and leaves memory unchanged.
REQ-022 SHALL produce no rsp_valid for an accepted write.
REQ-023 SHALL return data for a read accepted in cycle T on rsp_valid/rsp_dout of the same port at T+RD_LATENCY. RD_LATENCY is 1, or 2 with REQ-029.
REQ-024 SHALL sustain one accepted access per port per cycle when there is no conflict; there is no response backpressure.
REQ-025 SHALL keep rsp_dout stable between responses.
REQ-026 SHALL, for a read and a write to the same bank/row in one cycle, grant only one of them. A read granted after the write returns the new data.

Reset
REQ-027 SHALL, while rst is high:
  - set rsp_valid = 0 and rsp_dout = 0;
  - clear all arbiter pointers to 0;
  - discard in-flight reads;
  - force req_ready = 0.
  Memory contents SHALL NOT be reset.
REQ-028 SHALL, when rst asserts mid-operation, drive rsp_valid low from the next cycle, and SHALL emit no stale response after rst deasserts.

Configuration
REQ-029 SHALL support macro BANKED_BRAM_ARBITER_OUT_REG_EN:
  - defined: an extra output register stage on rsp_valid/rsp_dout, RD_LATENCY = 2;
  - undefined: RD_LATENCY = 1.
  Arbitration and throughput SHALL be identical in both builds.

Structure
REQ-030 SHALL place the following in shared package banked_bram_pkg: a clog2 function, the bank-index and row-index extraction functions, and the RD_LATENCY constant selection.
REQ-031 SHALL implement the per-bank arbiter as sub-module rr_arbiter (NUM_PORTS request in, one-hot grant out, pointer update on grant), instantiated BANKS times. Bank storage SHALL be an inferred simple array per bank.

Verification
REQ-032 SHALL cover the no-conflict case: port0 writes 0xBEEF at addr 0x004 (bank 0) and port1 writes 0x1234 at 0x005 (bank 1) in one cycle -> both req_ready high. Then both read the same addresses -> rsp_valid both high at T+1 with 0xBEEF/0x1234.
REQ-033 SHALL cover a conflict: ports 0 and 1 both read bank 2 continuously after reset -> grants alternate 0,1,0,1; each port gets one rsp_valid every 2 cycles.
REQ-034 SHALL cover strobes: write 0xAAAA, then write 0x55FF with strobe 2'b01 to the same address, then read -> 0xAAFF.
REQ-035 SHALL cover reset mid-operation: rst asserted one cycle after a read is accepted -> rsp_valid stays 0 through reset and after release; pointers restart at port 0.
REQ-036 SHALL cover the macro build: with BANKED_BRAM_ARBITER_OUT_REG_EN defined, rerun REQ-032 -> data appears at T+2, never at T+1.
REQ-037 SHALL cover same-row write/read: port0 writes 0x0F0F and port1 reads the same address in one cycle -> port0 granted (pointer 0). Port1 is granted next cycle and returns 0x0F0F.

Source files
------------

// File: rtl/banked_bram_pkg.sv
// Shared helpers for the banked BRAM arbiter: address split and read latency.
// RD_LATENCY follows BANKED_BRAM_ARBITER_OUT_REG_EN (2 when defined, 1 otherwise).
package banked_bram_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Low-order interleave: bank from the bottom bits, row from the rest.
    function automatic logic [31:0] bank_index(input logic [31:0] addr, input int bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] row_index(input logic [31:0] addr, input int bank_bits);
        return addr >> bank_bits;
    endfunction

`ifdef BANKED_BRAM_ARBITER_OUT_REG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past the winner.
module rr_arbiter
    import banked_bram_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr_p0;
    logic [PTR_W-1:0] ptr_nxt;
    int               best_dist;
    int               win_idx;

    // Winner is the requester at the smallest rotational distance from the pointer.
    always_comb begin
        best_dist = NUM_PORTS;
        win_idx   = 0;
        gnt       = '0;
        ptr_nxt   = ptr_p0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (req[j] && (((j + NUM_PORTS - int'(ptr_p0)) % NUM_PORTS) < best_dist)) begin
                best_dist = (j + NUM_PORTS - int'(ptr_p0)) % NUM_PORTS;
                win_idx   = j;
            end
        end
        if (best_dist < NUM_PORTS) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                gnt[j] = (win_idx == j);
            end
            ptr_nxt = PTR_W'((win_idx + 1) % NUM_PORTS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_p0 <= '0;
        end else if (|gnt) begin
            ptr_p0 <= ptr_nxt;
        end
    end

endmodule

// File: rtl/banked_bram_arbiter.sv
// Multi-port banked BRAM with per-bank round-robin arbitration and byte strobes.
// Define BANKED_BRAM_ARBITER_OUT_REG_EN to add an output register (read latency 2).
module banked_bram_arbiter
    import banked_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_PORTS  = 2,
    parameter int BANKS      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_wren,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0] req_wrstrb,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_din,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_dout
);

    localparam int BANK_BITS = clog2(BANKS);
    localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int DEPTH     = 1 << ROW_BITS;

    logic [SEL_W-1:0]      port_bank     [NUM_PORTS];
    logic [ROW_W-1:0]      port_row      [NUM_PORTS];
    logic [NUM_PORTS-1:0]  bank_req      [BANKS];
    logic [NUM_PORTS-1:0]  bank_gnt      [BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata_p1 [BANKS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_bank[p] = SEL_W'(bank_index(32'(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]), BANK_BITS));
            port_row[p]  = ROW_W'(row_index(32'(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]), BANK_BITS));
        end
    end

    // Requests are masked during reset so no grant and no pointer move can occur.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                bank_req[b][p] = !rst && req_valid[p] && (int'(port_bank[p]) == b);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int b = 0; b < BANKS; b++) begin
            req_ready = req_ready | bank_gnt[b];
        end
    end

    // ---- stage p0 -> p1: per-bank arbitration, write, synchronous read ----
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic                  we;
        logic                  re;
        logic [ROW_W-1:0]      row;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
        logic [DATA_WIDTH-1:0] rdata_p1;

        rr_arbiter #(
            .NUM_PORTS(NUM_PORTS)
        ) u_arb (
            .clk(clk),
            .rst(rst),
            .req(bank_req[b]),
            .gnt(bank_gnt[b])
        );

        always_comb begin
            we    = 1'b0;
            re    = 1'b0;
            row   = '0;
            wdata = '0;
            wstrb = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    we    = req_wren[p];
                    re    = !req_wren[p];
                    row   = port_row[p];
                    wdata = req_din[p*DATA_WIDTH +: DATA_WIDTH];
                    wstrb = req_wrstrb[p*STRB_WIDTH +: STRB_WIDTH];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (we) begin
                for (int k = 0; k < STRB_WIDTH; k++) begin
                    if (wstrb[k]) begin
                        mem[row][k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end
            if (re) begin
                rdata_p1 <= mem[row];
            end
        end

        assign bank_rdata_p1[b] = rdata_p1;
    end

    logic [NUM_PORTS-1:0]            rd_vld_p1;
    logic [SEL_W-1:0]                rd_bank_p1 [NUM_PORTS];
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout_hold_p1;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= '0;
        end else begin
            rd_vld_p1 <= req_valid & req_ready & ~req_wren;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_bank_p1[p] <= port_bank[p];
        end
    end

    // Each port keeps its last read word until a new response replaces it.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_data_c[p*DATA_WIDTH +: DATA_WIDTH] = rd_vld_p1[p] ? bank_rdata_p1[rd_bank_p1[p]]
                                                                  : dout_hold_p1[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_hold_p1 <= '0;
        end else begin
            dout_hold_p1 <= rsp_data_c;
        end
    end

`ifdef BANKED_BRAM_ARBITER_OUT_REG_EN
    // ---- stage p1 -> p2: optional output register ----
    logic [NUM_PORTS-1:0]            vld_p2;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= '0;
            dout_p2 <= '0;
        end else begin
            vld_p2  <= rd_vld_p1;
            dout_p2 <= rsp_data_c;
        end
    end

    assign rsp_valid = rst ? '0 : vld_p2;
    assign rsp_dout  = rst ? '0 : dout_p2;
`else
    assign rsp_valid = rst ? '0 : rd_vld_p1;
    assign rsp_dout  = rst ? '0 : rsp_data_c;
`endif

endmodule

// File: tb/tb_banked_bram_arbiter.sv
// Scoreboard bench for banked_bram_arbiter (2 ports, 4 banks, 16-bit words).
module tb_banked_bram_arbiter;

    localparam int LAT = banked_bram_pkg::RD_LATENCY;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_wren = '0;
    logic [3:0]  req_wrstrb = '0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_din = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_dout;

    banked_bram_arbiter #(
        .DATA_WIDTH(16),
        .STRB_WIDTH(2),
        .ADDR_WIDTH(10),
        .NUM_PORTS(2),
        .BANKS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wren(req_wren),
        .req_wrstrb(req_wrstrb),
        .req_addr(req_addr),
        .req_din(req_din),
        .rsp_valid(rsp_valid),
        .rsp_dout(rsp_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q [2][$];
    logic [15:0] model [1024];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        v_valid [2];
    logic        v_ready [2];
    logic        v_wren  [2];
    logic [1:0]  v_strb  [2];
    logic [9:0]  v_addr  [2];
    logic [15:0] v_din   [2];
    logic        v_rvld  [2];
    logic [15:0] v_dout  [2];

    assign v_valid[0] = req_valid[0];
    assign v_valid[1] = req_valid[1];
    assign v_ready[0] = req_ready[0];
    assign v_ready[1] = req_ready[1];
    assign v_wren[0]  = req_wren[0];
    assign v_wren[1]  = req_wren[1];
    assign v_strb[0]  = req_wrstrb[1:0];
    assign v_strb[1]  = req_wrstrb[3:2];
    assign v_addr[0]  = req_addr[9:0];
    assign v_addr[1]  = req_addr[19:10];
    assign v_din[0]   = req_din[15:0];
    assign v_din[1]   = req_din[31:16];
    assign v_rvld[0]  = rsp_valid[0];
    assign v_rvld[1]  = rsp_valid[1];
    assign v_dout[0]  = rsp_dout[15:0];
    assign v_dout[1]  = rsp_dout[31:16];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push expected read data on acceptance, pop on response.
    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                n_checks++;
                if (v_rvld[p] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rsp_during_reset port%0d: rsp_valid=%b required 0", p, v_rvld[p]);
                end
                sb_q[p].delete();
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (v_rvld[p] === 1'b1) begin
                    n_checks++;
                    if (sb_q[p].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rsp port%0d: data=%h at cycle %0d, none pending", p, v_dout[p], cyc);
                    end else begin
                        exp_t e;
                        e = sb_q[p].pop_front();
                        if (e.due != cyc || v_dout[p] !== e.data) begin
                            n_fail++;
                            $display("FAIL rsp_data port%0d: got %h at cycle %0d, required %h at cycle %0d",
                                     p, v_dout[p], cyc, e.data, e.due);
                        end
                    end
                end else if (sb_q[p].size() != 0 && sb_q[p][0].due <= cyc) begin
                    exp_t e;
                    e = sb_q[p].pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_rsp port%0d: rsp_valid=0 at cycle %0d, required data %h",
                             p, cyc, e.data);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (v_valid[p] === 1'b1 && v_ready[p] === 1'b1) begin
                    if (v_wren[p]) begin
                        if (v_strb[p][0]) model[v_addr[p]][7:0]  = v_din[p][7:0];
                        if (v_strb[p][1]) model[v_addr[p]][15:8] = v_din[p][15:8];
                    end else begin
                        exp_t e;
                        e.data = model[v_addr[p]];
                        e.due  = cyc + LAT;
                        sb_q[p].push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic v, input logic w, input logic [1:0] s,
                         input logic [9:0] a, input logic [15:0] d);
        if (!p) begin
            req_valid[0] = v; req_wren[0] = w; req_wrstrb[1:0] = s;
            req_addr[9:0] = a; req_din[15:0] = d;
        end else begin
            req_valid[1] = v; req_wren[1] = w; req_wrstrb[3:2] = s;
            req_addr[19:10] = a; req_din[31:16] = d;
        end
    endtask

    task automatic idle_all();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    endtask

    task automatic pulse_reset();
        idle_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'b11, 10'h001, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'b11, 10'h002, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_dout !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state: ready=%b rsp_valid=%b rsp_dout=%h required 00/00/0",
                         req_ready, rsp_valid, rsp_dout);
            end
        end
        step();
        idle_all();
        rst = 1'b0;
    endtask

    task automatic test_no_conflict();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h004, 16'hBEEF);
        drive(1'b1, 1'b1, 1'b1, 2'b11, 10'h005, 16'h1234);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL no_conflict_write_ready: got %b required 11", req_ready);
        end
        step();
        drive(1'b0, 1'b1, 1'b0, 2'b00, 10'h004, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 10'h005, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL no_conflict_read_ready: got %b required 11", req_ready);
        end
        step();
        idle_all();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < LAT) begin
                if (rsp_valid !== 2'b00) begin
                    n_fail++;
                    $display("FAIL no_conflict_early_rsp: rsp_valid=%b at T+%0d required 00", rsp_valid, k);
                end
            end else if (rsp_valid !== 2'b11 || rsp_dout !== 32'h1234BEEF) begin
                n_fail++;
                $display("FAIL no_conflict_rsp: rsp_valid=%b rsp_dout=%h required 11/1234beef",
                         rsp_valid, rsp_dout);
            end
        end
        step();
    endtask

    task automatic test_conflict();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h002, 16'h2222);
        step();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h006, 16'h6666);
        step();
        pulse_reset();
        drive(1'b0, 1'b1, 1'b0, 2'b00, 10'h002, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 10'h006, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL conflict_grant cycle%0d: got %b required %b",
                         i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            step();
        end
        idle_all();
        repeat (LAT + 1) step();
    endtask

    task automatic test_strobe();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h010, 16'hAAAA);
        @(negedge clk);
        step();
        drive(1'b0, 1'b1, 1'b1, 2'b01, 10'h010, 16'h55FF);
        @(negedge clk);
        step();
        drive(1'b0, 1'b1, 1'b1, 2'b00, 10'h010, 16'h1111);
        @(negedge clk);
        n_checks++;
        if (req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_strobe_accept: ready=%b required 1", req_ready[0]);
        end
        step();
        drive(1'b0, 1'b1, 1'b0, 2'b00, 10'h010, 16'h0000);
        step();
        idle_all();
        repeat (LAT - 1) step();
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_dout[15:0] !== 16'hAAFF) begin
            n_fail++;
            $display("FAIL strobe_merge: rsp_valid=%b data=%h required 1/aaff", rsp_valid[0], rsp_dout[15:0]);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (rsp_dout[15:0] !== 16'hAAFF) begin
            n_fail++;
            $display("FAIL dout_hold: data=%h required aaff", rsp_dout[15:0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h003, 16'h3333);
        step();
        drive(1'b0, 1'b1, 1'b0, 2'b00, 10'h003, 16'h0000);
        @(negedge clk);
        step();
        idle_all();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_rsp cycle%0d: rsp_valid=%b required 00", i, rsp_valid);
            end
            step();
            if (i == 1) rst = 1'b0;
        end
        drive(1'b0, 1'b1, 1'b0, 2'b00, 10'h003, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 10'h007, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_pointer: ready=%b required 01", req_ready);
        end
        step();
        idle_all();
        repeat (LAT + 1) step();
    endtask

    task automatic test_same_row();
        pulse_reset();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 10'h020, 16'h0F0F);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 10'h020, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL same_row_first: ready=%b required 01", req_ready);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL same_row_second: ready=%b required 10", req_ready);
        end
        step();
        idle_all();
        repeat (LAT - 1) step();
        @(negedge clk);
        n_checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_dout[31:16] !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL same_row_data: rsp_valid=%b data=%h required 1/0f0f", rsp_valid[1], rsp_dout[31:16]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                drive(1'b0, 1'b1, (pass == 0), 2'b11, 10'(10'h040 + i), 16'($urandom));
                drive(1'b1, 1'b1, (pass == 0), 2'b11, 10'(10'h080 + i + 2), 16'($urandom));
                @(negedge clk);
                n_checks++;
                if (req_ready !== 2'b11) begin
                    n_fail++;
                    $display("FAIL back_to_back pass%0d cycle%0d: ready=%b required 11", pass, i, req_ready);
                end
                step();
            end
        end
        idle_all();
        repeat (LAT + 1) step();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_no_conflict();
        test_conflict();
        test_strobe();
        test_reset_mid();
        test_same_row();
        test_back_to_back();
        repeat (4) step();
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (sb_q[p].size() != 0) begin
                n_fail++;
                $display("FAIL drain port%0d: %0d responses outstanding, required 0", p, sb_q[p].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
